// File: rtl/axi2apb_rw_arbiter_if.sv
// Request/grant bundle between the AXI channel engines and the APB port arbiter.
//   slave  : arbiter side (takes requests/done pulses, drives grants and status)
//   master : engine side (drives requests/done pulses, observes grants)
// Signals:
//   wr_req_i / rd_req_i   engine wants the APB port for one burst
//   wr_done_i / rd_done_i one-cycle pulse, owning engine finished its burst
//   wr_gnt_o / rd_gnt_o   engine owns the APB port
//   busy_o                any grant active
//   owner_o               current or most recent owner (0 = write, 1 = read)
//   timeout_o             one-cycle pulse, grant revoked by the hold timer
interface axi2apb_rw_arbiter_if;
  logic wr_req_i;
  logic wr_done_i;
  logic rd_req_i;
  logic rd_done_i;
  logic wr_gnt_o;
  logic rd_gnt_o;
  logic busy_o;
  logic owner_o;
  logic timeout_o;

  modport slave (
    input  wr_req_i, wr_done_i, rd_req_i, rd_done_i,
    output wr_gnt_o, rd_gnt_o, busy_o, owner_o, timeout_o
  );

  modport master (
    output wr_req_i, wr_done_i, rd_req_i, rd_done_i,
    input  wr_gnt_o, rd_gnt_o, busy_o, owner_o, timeout_o
  );
endinterface

// File: rtl/axi2apb_rw_arbiter.sv
// APB port arbiter between the write-path and read-path engines of the
// AXI-to-APB bridge. One whole burst per grant, round-robin on contention,
// grant held until the owner's done pulse, hung grants revoked after TIMEOUT
// cycles (TIMEOUT = 0 disables revocation).
// Ports:
//   clk    bridge clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    request/grant bundle (slave modport), all outputs registered
//
// state  | meaning
// IDLE   | no grant; arbitrate among pending requests
// GNT_WR | write engine owns the APB port
// GNT_RD | read engine owns the APB port
module axi2apb_rw_arbiter #(
  parameter int TIMEOUT = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  axi2apb_rw_arbiter_if.slave  bus
);

  // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   hold_cnt, hold_cnt_n;
  logic            last_owner, last_owner_n;
  logic            owner_n;
  logic            timeout_n;
  logic            hold_expired;

  assign hold_expired = TIMEOUT_EN && (hold_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      last_owner    <= 1'b1;
      bus.wr_gnt_o  <= 1'b0;
      bus.rd_gnt_o  <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.owner_o   <= 1'b0;
      bus.timeout_o <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      last_owner    <= last_owner_n;
      bus.wr_gnt_o  <= (state_n == GNT_WR);
      bus.rd_gnt_o  <= (state_n == GNT_RD);
      bus.busy_o    <= (state_n != IDLE);
      bus.owner_o   <= owner_n;
      bus.timeout_o <= timeout_n;
    end
  end

  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    last_owner_n = last_owner;
    timeout_n    = 1'b0;

    unique case (state)
      IDLE: begin
        hold_cnt_n = '0;
        // On a tie, the engine that did not own the port last time wins.
        if (bus.wr_req_i && (!bus.rd_req_i || last_owner)) begin
          state_n = GNT_WR;
        end else if (bus.rd_req_i) begin
          state_n = GNT_RD;
        end
      end
      GNT_WR: begin
        // done takes priority over a simultaneous timeout.
        if (bus.wr_done_i) begin
          state_n      = IDLE;
          last_owner_n = 1'b0;
        end else if (hold_expired) begin
          state_n      = IDLE;
          last_owner_n = 1'b0;
          timeout_n    = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      GNT_RD: begin
        if (bus.rd_done_i) begin
          state_n      = IDLE;
          last_owner_n = 1'b1;
        end else if (hold_expired) begin
          state_n      = IDLE;
          last_owner_n = 1'b1;
          timeout_n    = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // owner_o follows the grant and keeps its value through IDLE.
    owner_n = bus.owner_o;
    if (state_n == GNT_WR) begin
      owner_n = 1'b0;
    end else if (state_n == GNT_RD) begin
      owner_n = 1'b1;
    end
  end

endmodule

// File: doc/axi2apb_rw_arbiter.md
# axi2apb_rw_arbiter

Grants the single APB master port of the AXI-to-APB bridge to either the write-path engine (AW/W/B sequencing) or the read-path engine (AR/R sequencing), one whole AXI burst at a time. Uses round-robin on contention, holds the grant until the owning engine signals burst completion, and revokes a hung grant after a programmable timeout. Sits between the two channel engines and the APB master FSM inside the bridge top.

## Interface
- `TIMEOUT`, 256: maximum cycles a grant may be held without `done`; 0 disables the timeout.
- `clk`  in  1  bridge clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_req_i`  in  1  write engine has an accepted AW burst and requests the APB port.
- `wr_done_i`  in  1  write engine has finished its last APB transfer; one-cycle pulse.
- `rd_req_i`  in  1  read engine has an accepted AR burst and requests the APB port.
- `rd_done_i`  in  1  read engine has finished its last APB transfer; one-cycle pulse.
- `wr_gnt_o`  out  1  write engine owns the APB port.
- `rd_gnt_o`  out  1  read engine owns the APB port.
- `busy_o`  out  1  a grant is active (`wr_gnt_o | rd_gnt_o`).
- `owner_o`  out  1  current or most recent owner: 0 = write, 1 = read.
- `timeout_o`  out  1  one-cycle pulse: grant revoked by timeout.

## Operation
- States: IDLE, GNT_WR, GNT_RD. All outputs are registered.
- IDLE:
  - Only `wr_req_i`: go to GNT_WR.
  - Only `rd_req_i`: go to GNT_RD.
  - Both: grant the requester that is not `last_owner`.
  - Neither: stay in IDLE.
- GNT_WR / GNT_RD:
  - The grant is held while the owner's `done` is low. The owner's `req` is not examined; a dropped `req` does not end the grant.
  - Owner's `done` high: return to IDLE and set `last_owner` to the owner.
  - `done` from the non-owner is ignored in every state.
- Timeout:
  - `hold_cnt`, width `$clog2(TIMEOUT+1)`, clears on entry to a grant state and increments each cycle the grant is held.
  - When `hold_cnt == TIMEOUT-1` and `done` is low: return to IDLE, pulse `timeout_o`, and set `last_owner` to the revoked owner.
  - `done` and timeout in the same cycle: `done` wins and `timeout_o` stays 0.
  - With `TIMEOUT == 0`: no revocation, and `timeout_o` is tied to 0.
- A requester may withdraw `req` before it is granted without side effects.
- `wr_gnt_o` and `rd_gnt_o` are never both 1.

## Timing
- Reset values: `wr_gnt_o=0`, `rd_gnt_o=0`, `busy_o=0`, `owner_o=0`, `timeout_o=0`, internal `last_owner=1` (read), so write wins the first tie. `hold_cnt=0`, state IDLE.
- Reset asserted mid-grant: the grant drops immediately (asynchronously). The engines must abandon their APB transfer.
- Grant latency: `req` sampled high in IDLE at edge N gives grant high after edge N (visible in cycle N+1).
- Release: `done` sampled at edge M drops the grant after edge M.
- Turnaround: state is IDLE for at least one cycle between any two grants. Earliest next grant is visible 2 cycles after `done` was sampled.
- Maximum hold: a grant visible from cycle G is revoked after edge G+TIMEOUT-1, so it is low from cycle G+TIMEOUT. `timeout_o` is high for exactly that one cycle.
- `owner_o` updates together with the grant and holds its value through IDLE.

## Test plan
- Reset, then `wr_req_i=1` only: `wr_gnt_o=1` one cycle later. A `wr_done_i` pulse gives `wr_gnt_o=0` the next cycle and `owner_o=0`.
- Both requests high continuously, each owner pulses `done` 3 cycles after its grant: grants alternate WR, RD, WR, RD with exactly one IDLE cycle between them.
- `TIMEOUT=8`, `rd_req_i=1`, `rd_done_i` never pulsed: `rd_gnt_o` high for exactly 8 cycles, `timeout_o` pulses once as it drops, and a pending `wr_req_i` is granted 1 cycle later.
- `rd_done_i` pulsed during GNT_WR: no effect, and `wr_gnt_o` stays 1 until `wr_done_i`.
- `done` asserted on the cycle `hold_cnt == TIMEOUT-1`: normal release with `timeout_o=0`.
- `rst_n` dropped mid-GNT_RD: `rd_gnt_o` goes to 0 asynchronously. After release, simultaneous requests grant write first.
